// File: rtl/config_loader.sv
// Word-serial configuration loader: assembles a valid/ready word stream into the tile config bus
// and sequences the tile reset. Define CONFIG_LOADER_CHECKSUM_EN to add the XOR check-word stage.
module config_loader #(
  parameter int unsigned CONFIG_WIDTH  = 644,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    tile_nreset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned WCW       = $clog2(NUM_WORDS + 1);
  localparam int unsigned DCW       = $clog2(RELEASE_DELAY + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StWait, StDone, StError} state_e;

  state_e                  state_q, state_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [DCW-1:0]          delay_q, delay_d;
  logic [CONFIG_WIDTH-1:0] config_d;
  logic                    tile_nreset_d, busy_d, done_d;
  logic                    handshake, last_word;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum_q, csum_d;
  logic                  error_q, error_d;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign handshake = cfg_valid && cfg_ready;
  assign last_word = (word_cnt_q == WCW'(NUM_WORDS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      delay_q     <= '0;
      config_out  <= '0;
      tile_nreset <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      delay_q     <= delay_d;
      config_out  <= config_d;
      tile_nreset <= tile_nreset_d;
      busy        <= busy_d;
      done        <= done_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      error_q     <= error_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    delay_d    = delay_q;
    config_d   = config_out;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StLoad;
          word_cnt_d = '0;
          config_d   = '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      StLoad: begin
        if (abort) begin
          state_d    = StIdle;
          word_cnt_d = '0;
          config_d   = '0;
        end else if (handshake) begin
          // Pad bits of the final word have no destination and simply drop out here.
          for (int unsigned i = 0; i < CONFIG_WIDTH; i++) begin
            if (WCW'(i / WORD_WIDTH) == word_cnt_q) config_d[i] = cfg_data[i % WORD_WIDTH];
          end
`ifdef CONFIG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ cfg_data;
`endif
          if (last_word) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StWait;
`endif
            delay_d = DCW'(RELEASE_DELAY - 1);
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      StCheck: begin
        if (abort) begin
          state_d    = StIdle;
          word_cnt_d = '0;
          config_d   = '0;
        end else if (handshake) begin
          if (cfg_data == csum_q) begin
            state_d = StWait;
          end else begin
            state_d  = StError;
            config_d = '0;
          end
        end
      end
`endif
      StWait: begin
        if (abort) begin
          state_d    = StIdle;
          word_cnt_d = '0;
          config_d   = '0;
        end else if (delay_q == '0) begin
          state_d = StDone;
        end else begin
          delay_d = delay_q - DCW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    cfg_ready     = (state_q == StLoad) || (state_q == StCheck);
    busy_d        = (state_d == StLoad) || (state_d == StCheck) || (state_d == StWait);
    done_d        = (state_d == StDone);
    tile_nreset_d = (state_d == StDone);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    error_d       = (state_d == StError);
`endif
  end

endmodule

// File: tb/tb_config_loader.sv
// Randomized self-checking bench for config_loader against a word-array reference model.
module tb_config_loader;

  localparam int CW        = 644;
  localparam int WW        = 32;
  localparam int RD        = 2;
  localparam int NUM_WORDS = (CW + WW - 1) / WW;

  logic          clock = 1'b0;
  logic          reset, start, abort, cfg_valid;
  logic [WW-1:0] cfg_data;
  logic          cfg_ready, tile_nreset, busy, done, error;
  logic [CW-1:0] config_out;

  logic [WW-1:0] words [NUM_WORDS];
  int n_tests = 0;
  int n_fail  = 0;

  config_loader #(
    .CONFIG_WIDTH (CW),
    .WORD_WIDTH   (WW),
    .RELEASE_DELAY(RD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .config_out (config_out),
    .tile_nreset(tile_nreset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected config bus after the first n words: word k lands at bit k*WW, overflow discarded.
  function automatic logic [CW-1:0] model_cfg(input int n);
    logic [NUM_WORDS*WW-1:0] full;
    full = '0;
    for (int k = 0; k < n; k++) full[k*WW +: WW] = words[k];
    return full[CW-1:0];
  endfunction

  function automatic logic [WW-1:0] xor_words();
    logic [WW-1:0] x;
    x = '0;
    for (int k = 0; k < NUM_WORDS; k++) x ^= words[k];
    return x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input int gap);
    bit accepted;
    for (int g = 0; g < gap; g++) begin
      cfg_valid = 1'b0;
      cfg_data  = $urandom;
      tick();
      check("busy_gap", busy, 1);
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    accepted  = 1'b0;
    for (int n = 0; n < 8 && !accepted; n++) begin
      if (cfg_ready) accepted = 1'b1;
      tick();
    end
    if (!accepted) check("hs_timeout", 0, 1);
    cfg_valid = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ld_busy", busy, 1);
    check("ld_ready", cfg_ready, 1);
    check("ld_cfg0", config_out, '0);
    check("ld_nrst", tile_nreset, 0);
    check("ld_done", done, 0);
    check("ld_err", error, 0);
  endtask

  task automatic load_all(input int max_gap, input bit csum_good);
    bit finish_ok;
    start_load();
    for (int k = 0; k < NUM_WORDS; k++) send_word(words[k], $urandom_range(0, max_gap));
    finish_ok = 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    check("chk_ready", cfg_ready, 1);
    send_word(csum_good ? xor_words() : (xor_words() ^ 32'h1), 0);
    if (!csum_good) begin
      finish_ok = 1'b0;
      check("err_flag", error, 1);
      check("err_cfg", config_out, '0);
      check("err_nrst", tile_nreset, 0);
      check("err_busy", busy, 0);
    end
`endif
    if (finish_ok) begin
      check("wait_busy", busy, 1);
      check("wait_nrst", tile_nreset, 0);
      check("wait_done", done, 0);
      for (int d = 1; d < RD; d++) begin
        tick();
        check("wait_nrst_d", tile_nreset, 0);
      end
      tick();
      check("rel_nrst", tile_nreset, 1);
      check("rel_done", done, 1);
      check("rel_busy", busy, 0);
      check("rel_ready", cfg_ready, 0);
      check("rel_err", error, 0);
      check("rel_cfg", config_out, model_cfg(NUM_WORDS));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    #2;
    check("rst_cfg", config_out, '0);
    check("rst_nrst", tile_nreset, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Abort while idle changes nothing.
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", busy, 0);

    // Full back-to-back load of 1..21.
    for (int k = 0; k < NUM_WORDS; k++) words[k] = WW'(k + 1);
    load_all(0, 1'b1);
    check("full_lo", config_out[31:0], 1);
    check("full_hi", config_out[643:640], 4'h5);

    // Same data with backpressure; also reload from DONE.
    load_all(3, 1'b1);

    // Pad truncation.
    words[NUM_WORDS-1] = 32'hFFFF_FFFF;
    load_all(2, 1'b1);
    check("pad_hi", config_out[643:640], 4'hF);

    // Random data with random gaps.
    repeat (3) begin
      for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
      load_all(3, 1'b1);
    end

    // DONE holds config regardless of stream activity and abort.
    for (int c = 0; c < 4; c++) begin
      cfg_valid = 1'($urandom); cfg_data = $urandom; abort = (c == 2);
      tick();
      check("done_stable", config_out, model_cfg(NUM_WORDS));
      check("done_hold", done, 1);
    end
    cfg_valid = 1'b0; abort = 1'b0;

    // Abort after word 10, then a clean load.
    for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
    start_load();
    for (int k = 0; k < 10; k++) send_word(words[k], $urandom_range(0, 2));
    check("part_cfg", config_out, model_cfg(10));
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cfg", config_out, '0);
    check("abort_nrst", tile_nreset, 0);
    check("abort_ready", cfg_ready, 0);
    load_all(1, 1'b1);

    // Start during LOAD ignored; abort+start together goes idle.
    start_load();
    for (int k = 0; k < 5; k++) send_word(words[k], 0);
    start = 1'b1; tick(); start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ign", config_out, model_cfg(5));
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    check("abst_busy", busy, 0);
    check("abst_cfg", config_out, '0);

    // Asynchronous reset mid-load.
    start_load();
    for (int k = 0; k < 7; k++) send_word(words[k], 0);
    #2 reset = 1'b1;
    #1;
    check("arst_cfg", config_out, '0);
    check("arst_busy", busy, 0);
    check("arst_ready", cfg_ready, 0);
    #1 reset = 1'b0;
    tick();
    load_all(0, 1'b1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
    load_all(1, 1'b0);
    start_load();
    check("err_clear", error, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    load_all(0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
